// File: rtl/fork_finger_dispatcher_if.sv
// fork_finger_dispatcher_if
//   Bundles the arm-side phit handshake and the per-finger output lanes of
//   the fork stage into one interface.
//   Ports (signals):
//     arm_data_in / arm_sent_req_in / arm_new_in / arm_vc_no_in : incoming phit
//     arm_ready_out                                           : arm-side ready
//     fingers_data_out / fingers_vc_no_out                    : packed lane heads
//     fingers_sent_req_out / fingers_new_out                  : lane valid / header flag
//     fingers_ready_in                                        : lane ready
//   Modports: master = arm-side driver / finger sink, slave = the fork stage.
interface fork_finger_dispatcher_if #(
  parameter int no_fingers              = 6,
  parameter int floorplusone_log2_no_vc = 4,
  parameter int phit_size               = 16
);
  logic [phit_size-1:0]                          arm_data_in;
  logic                                          arm_sent_req_in;
  logic                                          arm_new_in;
  logic [floorplusone_log2_no_vc-1:0]            arm_vc_no_in;
  logic                                          arm_ready_out;
  logic [no_fingers*phit_size-1:0]               fingers_data_out;
  logic [no_fingers-1:0]                         fingers_sent_req_out;
  logic [no_fingers-1:0]                         fingers_new_out;
  logic [no_fingers*floorplusone_log2_no_vc-1:0] fingers_vc_no_out;
  logic [no_fingers-1:0]                         fingers_ready_in;

  modport master (
    output arm_data_in, arm_sent_req_in, arm_new_in, arm_vc_no_in, fingers_ready_in,
    input  arm_ready_out, fingers_data_out, fingers_sent_req_out, fingers_new_out,
           fingers_vc_no_out
  );

  modport slave (
    input  arm_data_in, arm_sent_req_in, arm_new_in, arm_vc_no_in, fingers_ready_in,
    output arm_ready_out, fingers_data_out, fingers_sent_req_out, fingers_new_out,
           fingers_vc_no_out
  );
endinterface

// File: rtl/fork_finger_dispatcher.sv
// fork_finger_dispatcher
//   Fork stage: steers each arm-side packet to one finger lane, decoded from
//   the header phit, through a per-finger FIFO. The destination is locked
//   for the whole packet (wormhole). Packets with an unroutable header and
//   stray body phits are discarded and counted in a saturating counter.
//   Optional feature macro: FORK_BROADCAST_EN -- an all-ones destination
//   field broadcasts the packet to every finger (state BCAST).
//   Ports:
//     clk      : clock, rising edge
//     rs       : synchronous active-low reset
//     bus      : fork_finger_dispatcher_if.slave (arm input, finger outputs)
//     drop_cnt : number of discarded packets, saturates at 255
//     busy     : FSM not idle or any FIFO holds data
module fork_finger_dispatcher #(
  parameter int no_fingers                   = 6,
  parameter int floorplusone_log2_no_fingers = 3,
  parameter int no_vc                        = 13,
  parameter int floorplusone_log2_no_vc      = 4,
  parameter int flit_size                    = 4,
  parameter int floorplusone_log2_flit_size  = 3,
  parameter int phit_size                    = 16,
  parameter int buf_size                     = 4,
  parameter int floorplusone_log2_buf_size   = 3,
  parameter int addr_place_in_header         = 0
) (
  input  logic                          clk,
  input  logic                          rs,
  fork_finger_dispatcher_if.slave       bus,
  output logic [7:0]                    drop_cnt,
  output logic                          busy
);
  localparam int FW = floorplusone_log2_no_fingers;
  localparam int VW = floorplusone_log2_no_vc;
  localparam int CW = floorplusone_log2_flit_size;
  localparam int BW = floorplusone_log2_buf_size;
  localparam int AW = (buf_size > 1) ? $clog2(buf_size) : 1;
  localparam int EW = 1 + VW + phit_size;

  if (flit_size < 1) begin : g_bad_flit
    $error("flit_size must be at least 1");
  end
  if (buf_size < 2) begin : g_bad_buf
    $error("buf_size must be at least 2");
  end
  if ((1 << VW) < no_vc) begin : g_bad_vc
    $error("floorplusone_log2_no_vc too narrow for no_vc");
  end

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
`ifdef FORK_BROADCAST_EN
    , BCAST
`endif
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Selects full[idx] without reading past the lane count for invalid idx.
  function automatic logic full_at(input logic [FW-1:0] idx,
                                   input logic [no_fingers-1:0] fv);
    logic r;
    r = 1'b0;
    for (int f = 0; f < no_fingers; f++)
      if (idx == FW'(f)) r = fv[f];
    return r;
  endfunction

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [FW-1:0]   dest_q, dest_n;

  logic [EW-1:0]   mem   [no_fingers][buf_size];
  logic [BW-1:0]   count [no_fingers];
  logic [AW-1:0]   widx  [no_fingers];
  logic [no_fingers-1:0] full, nonempty, push, pop;

  logic [FW-1:0]   d, tgt;
  logic            d_valid;
`ifdef FORK_BROADCAST_EN
  logic            d_bcast;
`endif
  logic            rdy, xfer;
  logic            push_en, push_bc, hdr, drop_inc;
  logic [EW-1:0]   entry;

  assign d       = bus.arm_data_in[addr_place_in_header +: FW];
  assign d_valid = {1'b0, d} < (FW+1)'(no_fingers);
`ifdef FORK_BROADCAST_EN
  assign d_bcast = &d;
`endif

  // Arm-side ready: header decode in IDLE, locked lane state otherwise.
  // Only registered FIFO counts feed this, so finger ready never reaches it.
  always_comb begin
    rdy = 1'b1;
    case (state)
      IDLE: begin
        if (bus.arm_new_in) begin
`ifdef FORK_BROADCAST_EN
          if (d_bcast) rdy = ~|full;
          else
`endif
          if (d_valid) rdy = !full_at(d, full);
        end
      end
      FWD:     rdy = !full_at(dest_q, full);
`ifdef FORK_BROADCAST_EN
      BCAST:   rdy = ~|full;
`endif
      default: rdy = 1'b1;
    endcase
  end

  assign bus.arm_ready_out = rs & rdy;
  assign xfer              = bus.arm_sent_req_in & bus.arm_ready_out;

  // Next-state / push / drop decisions
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dest_n   = dest_q;
    push_en  = 1'b0;
    push_bc  = 1'b0;
    hdr      = 1'b0;
    drop_inc = 1'b0;
    if (xfer) begin
      case (state)
        IDLE: begin
          if (!bus.arm_new_in) begin
            drop_inc = 1'b1;
          end
`ifdef FORK_BROADCAST_EN
          else if (d_bcast) begin
            push_bc = 1'b1;
            hdr     = 1'b1;
            if (flit_size > 1) begin
              state_n = BCAST;
              cnt_n   = CW'(1);
            end
          end
`endif
          else if (d_valid) begin
            push_en = 1'b1;
            hdr     = 1'b1;
            dest_n  = d;
            if (flit_size > 1) begin
              state_n = FWD;
              cnt_n   = CW'(1);
            end
          end else begin
            drop_inc = 1'b1;
            if (flit_size > 1) begin
              state_n = DROP;
              cnt_n   = CW'(1);
            end
          end
        end
        default: begin
          if (state == FWD) push_en = 1'b1;
`ifdef FORK_BROADCAST_EN
          if (state == BCAST) push_bc = 1'b1;
`endif
          if (cnt == CW'(flit_size - 1)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rs) begin
      state    <= IDLE;
      cnt      <= '0;
      dest_q   <= '0;
      drop_cnt <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      dest_q <= dest_n;
      if (drop_inc) drop_cnt <= sat_inc8(drop_cnt);
    end
  end

  // Per-finger push/pop decode
  assign tgt   = (state == IDLE) ? d : dest_q;
  assign entry = {hdr, bus.arm_vc_no_in, bus.arm_data_in};

  always_comb begin
    for (int f = 0; f < no_fingers; f++) begin
      full[f]     = (count[f] == BW'(buf_size));
      nonempty[f] = (count[f] != '0);
      pop[f]      = nonempty[f] & bus.fingers_ready_in[f];
      push[f]     = push_bc | (push_en & (tgt == FW'(f)));
      widx[f]     = pop[f] ? AW'(count[f] - BW'(1)) : AW'(count[f]);
    end
  end

  // Shift FIFOs: slot 0 is the head; vacated slots are cleared so an empty
  // lane presents zeros on its outputs.
  always_ff @(posedge clk) begin
    for (int f = 0; f < no_fingers; f++) begin
      if (!rs) begin
        count[f] <= '0;
        for (int k = 0; k < buf_size; k++) mem[f][k] <= '0;
      end else begin
        if (pop[f]) begin
          for (int k = 0; k < buf_size - 1; k++) mem[f][k] <= mem[f][k+1];
          mem[f][buf_size-1] <= '0;
        end
        if (push[f]) mem[f][widx[f]] <= entry;
        count[f] <= count[f] + BW'(push[f]) - BW'(pop[f]);
      end
    end
  end

  // Finger outputs straight from the head slots
  for (genvar f = 0; f < no_fingers; f++) begin : g_out
    assign bus.fingers_data_out[f*phit_size +: phit_size] = mem[f][0][phit_size-1:0];
    assign bus.fingers_vc_no_out[f*VW +: VW]              = mem[f][0][phit_size +: VW];
    assign bus.fingers_new_out[f]                         = mem[f][0][EW-1];
    assign bus.fingers_sent_req_out[f]                    = nonempty[f];
  end

  assign busy = (state != IDLE) | (|nonempty);
endmodule

// File: tb/tb_fork_finger_dispatcher.sv
`timescale 1ns/1ps
module tb_fork_finger_dispatcher;
  localparam int NF = 6, FW = 3, NV = 13, VW = 4, FS = 4, CW = 3;
  localparam int PS = 16, BS = 4, BW = 3, AP = 0;
  localparam int EW = 1 + VW + PS;
`ifdef FORK_BROADCAST_EN
  localparam bit         BC_EN = 1'b1;
  localparam logic [2:0] BAD_D = 3'd6;
`else
  localparam bit         BC_EN = 1'b0;
  localparam logic [2:0] BAD_D = 3'd7;
`endif

  logic       clk = 1'b0;
  logic       rs  = 1'b0;
  logic [7:0] drop_cnt;
  logic       busy;

  fork_finger_dispatcher_if #(.no_fingers(NF), .floorplusone_log2_no_vc(VW),
                              .phit_size(PS)) bus ();

  fork_finger_dispatcher #(
    .no_fingers(NF), .floorplusone_log2_no_fingers(FW), .no_vc(NV),
    .floorplusone_log2_no_vc(VW), .flit_size(FS), .floorplusone_log2_flit_size(CW),
    .phit_size(PS), .buf_size(BS), .floorplusone_log2_buf_size(BW),
    .addr_place_in_header(AP)
  ) dut (
    .clk(clk), .rs(rs), .bus(bus), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Reference model: expected phits per finger, packet progress, drop count.
  logic [EW-1:0] expq [NF][$];
  int pkt_left = 0;
  int pkt_dest = 0;      // -1 discard, -2 broadcast, else finger index
  int m_drop   = 0;

  logic [NF-1:0] force_low = '0;
  bit            rand_rdy  = 1'b0;
  bit            gap_en    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit all_room();
    for (int f = 0; f < NF; f++) if (expq[f].size() >= BS) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_ready();
    int d;
    if (!rs) return 1'b0;
    if (pkt_left == 0) begin
      if (!bus.arm_new_in) return 1'b1;
      d = int'(bus.arm_data_in[AP +: FW]);
      if (BC_EN && d == (1 << FW) - 1) return all_room();
      if (d < NF) return expq[d].size() < BS;
      return 1'b1;
    end
    if (pkt_dest == -1) return 1'b1;
    if (pkt_dest == -2) return all_room();
    return expq[pkt_dest].size() < BS;
  endfunction

  function automatic bit model_busy();
    if (pkt_left != 0) return 1'b1;
    for (int f = 0; f < NF; f++) if (expq[f].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_flush();
    for (int f = 0; f < NF; f++) expq[f].delete();
    pkt_left = 0;
    pkt_dest = 0;
    m_drop   = 0;
  endfunction

  function automatic void model_accept();
    int d;
    logic [EW-1:0] e;
    if (pkt_left == 0) begin
      d = int'(bus.arm_data_in[AP +: FW]);
      e = {1'b1, bus.arm_vc_no_in, bus.arm_data_in};
      if (!bus.arm_new_in) begin
        if (m_drop < 255) m_drop++;
      end else if (BC_EN && d == (1 << FW) - 1) begin
        for (int f = 0; f < NF; f++) expq[f].push_back(e);
        pkt_left = FS - 1; pkt_dest = -2;
      end else if (d < NF) begin
        expq[d].push_back(e);
        pkt_left = FS - 1; pkt_dest = d;
      end else begin
        if (m_drop < 255) m_drop++;
        pkt_left = FS - 1; pkt_dest = -1;
      end
    end else begin
      e = {1'b0, bus.arm_vc_no_in, bus.arm_data_in};
      if (pkt_dest == -2) for (int f = 0; f < NF; f++) expq[f].push_back(e);
      else if (pkt_dest >= 0) expq[pkt_dest].push_back(e);
      pkt_left--;
    end
  endfunction

  // One clock: check arm-side outputs mid-cycle, update model on transfer,
  // then move to just after the next rising edge.
  task automatic step(output bit acc);
    @(negedge clk);
    chk("arm_ready", 64'(bus.arm_ready_out), 64'(model_ready()));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("busy", 64'(busy), 64'(model_busy()));
    acc = rs && bus.arm_sent_req_in && bus.arm_ready_out;
    if (!rs) model_flush();
    else if (acc) model_accept();
    @(posedge clk); #1;
    bus.fingers_ready_in = (rand_rdy ? NF'($urandom) : {NF{1'b1}}) & ~force_low;
  endtask

  task automatic idle(input int n);
    bit a;
    bus.arm_sent_req_in = 1'b0;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic drive_phit(input logic [PS-1:0] data, input logic nw, input logic [VW-1:0] vc);
    bit a;
    int budget;
    if (gap_en && $urandom_range(0, 2) == 0) idle(1);
    bus.arm_data_in = data; bus.arm_new_in = nw; bus.arm_vc_no_in = vc;
    bus.arm_sent_req_in = 1'b1;
    budget = 0; a = 1'b0;
    while (!a) begin
      step(a);
      budget++;
      if (!a && budget > 300) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: phit %0h not accepted after %0d cycles", data, budget);
        break;
      end
    end
    bus.arm_sent_req_in = 1'b0;
  endtask

  // Hold the current phit for n cycles expecting no acceptance, then
  // release all finger back-pressure and wait for it to be taken.
  task automatic stall_then_release(input string name, input int n,
                                    input logic [PS-1:0] data, input logic [VW-1:0] vc);
    bit a;
    int budget;
    bus.arm_data_in = data; bus.arm_new_in = 1'b1; bus.arm_vc_no_in = vc;
    bus.arm_sent_req_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      step(a);
      chk(name, 64'(a), 64'd0);
    end
    force_low = '0;
    bus.fingers_ready_in = {NF{1'b1}};
    budget = 0; a = 1'b0;
    while (!a && budget < 50) begin step(a); budget++; end
    chk({name, "_release"}, 64'(a), 64'd1);
    bus.arm_sent_req_in = 1'b0;
  endtask

  task automatic send_pkt(input logic [2:0] dest, input logic [VW-1:0] vc, input logic [PS-1:0] base);
    drive_phit({base[PS-1:3], dest}, 1'b1, vc);
    for (int i = 1; i < FS; i++) drive_phit(base + PS'(i), 1'b0, vc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sent_req"}, 64'(bus.fingers_sent_req_out), 64'd0);
    chk({tag, "_new"}, 64'(bus.fingers_new_out), 64'd0);
    chk({tag, "_vc"}, 64'(bus.fingers_vc_no_out), 64'd0);
    for (int f = 0; f < NF; f++)
      chk({tag, "_data"}, 64'(bus.fingers_data_out[f*PS +: PS]), 64'd0);
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Monitor: every finger pop is compared with the model's oldest entry.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rs) begin
        for (int f = 0; f < NF; f++) begin
          if (bus.fingers_sent_req_out[f]) begin
            if (expq[f].size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL finger%0d_unexpected: got phit %0h expected none", f,
                       bus.fingers_data_out[f*PS +: PS]);
            end else if (bus.fingers_ready_in[f]) begin
              chk($sformatf("finger%0d_phit", f),
                  64'({bus.fingers_new_out[f], bus.fingers_vc_no_out[f*VW +: VW],
                       bus.fingers_data_out[f*PS +: PS]}),
                  64'(expq[f].pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    bus.arm_data_in = '0; bus.arm_new_in = 1'b0; bus.arm_vc_no_in = '0;
    bus.arm_sent_req_in = 1'b0; bus.fingers_ready_in = '1;

    // Reset state
    rs = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    chk("reset_arm_ready", 64'(bus.arm_ready_out), 64'd0);
    rs = 1'b1;
    idle(1);

    // Single packet to finger 2
    send_pkt(3'd2, 4'd5, 16'hA000);
    idle(6);

    // Back-pressure: two packets to finger 1 while it refuses
    force_low = 6'b000010;
    bus.fingers_ready_in = ~force_low;
    send_pkt(3'd1, 4'd1, 16'hB000);
    stall_then_release("bp_stall", 3, 16'hB101, 4'd2);
    for (int i = 1; i < FS; i++) drive_phit(16'hB100 + 16'(i), 1'b0, 4'd2);
    idle(8);

    // Unroutable header, then a normal packet
    send_pkt(BAD_D, 4'd3, 16'hC000);
    idle(2);
    chk("bad_dest_drop", 64'(drop_cnt), 64'd1);
    send_pkt(3'd4, 4'd4, 16'hC100);
    idle(6);

    // Stray body phit in IDLE
    drive_phit(16'hD005, 1'b0, 4'd7);
    idle(2);
    chk("stray_drop", 64'(drop_cnt), 64'd2);

    // Reset in the middle of a packet
    drive_phit(16'hE003, 1'b1, 4'd6);
    drive_phit(16'hE001, 1'b0, 4'd6);
    rs = 1'b0;
    idle(1);
    rs = 1'b1;
    check_reset_outputs("midreset");
    drive_phit(16'hE002, 1'b0, 4'd6);
    drive_phit(16'hE003, 1'b0, 4'd6);
    idle(1);
    chk("midreset_drop", 64'(drop_cnt), 64'd2);
    idle(2);

`ifdef FORK_BROADCAST_EN
    // Broadcast stalls while finger 3 is full
    force_low = 6'b001000;
    bus.fingers_ready_in = ~force_low;
    send_pkt(3'd3, 4'd8, 16'hF000);
    stall_then_release("bcast_stall", 3, 16'hF107, 4'd9);
    for (int i = 1; i < FS; i++) drive_phit(16'hF100 + 16'(i), 1'b0, 4'd9);
    idle(10);
`endif

    // Randomized traffic with random finger readiness and gaps
    rand_rdy = 1'b1;
    gap_en   = 1'b1;
    for (int p = 0; p < 80; p++) begin
      if ($urandom_range(0, 9) == 0)
        drive_phit(16'($urandom), 1'b0, VW'($urandom_range(0, NV - 1)));
      else
        send_pkt(3'($urandom_range(0, 7)), VW'($urandom_range(0, NV - 1)), 16'($urandom));
    end
    rand_rdy = 1'b0;
    gap_en   = 1'b0;
    idle(20);
    for (int f = 0; f < NF; f++)
      chk($sformatf("finger%0d_drained", f), 64'(expq[f].size()), 64'd0);
    chk("final_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
